printf_word_serializer: RTL

- Downstream consumer of the printf merge stage's 128-bit message stream.
- Buffers each 128-bit message in a small FIFO and emits it as a sequence of 32-bit words on a narrower enq interface toward the host transport.
- The header word in bits [127:96] carries the word count, so short messages take fewer output beats.

---
 rtl/printf_word_serializer_if.sv | 22 ++
 rtl/printf_word_serializer.sv | 85 ++++++++
 2 files changed

// File: rtl/printf_word_serializer_if.sv
// Handshake bundle between the printf merge stage, the word serializer and the host transport.
// Upstream delivers 128-bit messages; downstream receives 32-bit words.
interface printf_word_serializer_if;
   logic         in_enq__ENA;
   logic [127:0] in_enq_v;
   logic         in_enq__RDY;
   logic         out_enq__ENA;
   logic [31:0]  out_enq_v;
   logic         out_enq_last;
   logic         out_enq__RDY;
   logic         busy;

   modport master (
      output in_enq__ENA, in_enq_v, out_enq__RDY,
      input  in_enq__RDY, out_enq__ENA, out_enq_v, out_enq_last, busy
   );

   modport slave (
      input  in_enq__ENA, in_enq_v, out_enq__RDY,
      output in_enq__RDY, out_enq__ENA, out_enq_v, out_enq_last, busy
   );
endinterface

// File: rtl/printf_word_serializer.sv
// Buffers 128-bit printf messages in a small FIFO and streams each one out as 1-4 words.
// The 3-bit count field in the header word sets how many words a message uses.
module printf_word_serializer #(
   parameter int DEPTH   = 2,
   parameter int CNT_LSB = 96
) (
   input  logic                    CLK,
   input  logic                    nRST,
   printf_word_serializer_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [127:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [1:0]    r_k;

   logic          w_push;
   logic          w_pop;
   logic          w_xfer;
   logic          w_nonempty;
   logic [127:0]  w_head;
   logic [2:0]    w_n;
   logic [1:0]    w_last_k;
   logic [31:0]   w_word;

   assign w_nonempty = (r_count != '0);
   assign w_head     = r_mem[r_rptr];
   assign w_n        = w_head[CNT_LSB +: 3];

   // A count of 0 or anything above 4 means a full four-word message.
   always_comb begin
      w_last_k = 2'd3;
      if (w_n >= 3'd1 && w_n <= 3'd4) w_last_k = 2'(w_n - 3'd1);
   end

   always_comb begin
      w_word = '0;
      if (w_nonempty) begin
         case (r_k)
            2'd0:    w_word = w_head[127:96];
            2'd1:    w_word = w_head[95:64];
            2'd2:    w_word = w_head[63:32];
            default: w_word = w_head[31:0];
         endcase
      end
   end

   // Accept-ready depends only on the occupancy register, never on the downstream ready.
   assign bus.in_enq__RDY  = ~nRST & (r_count < CW'(DEPTH));
   assign bus.out_enq__ENA = w_nonempty & bus.out_enq__RDY;
   assign bus.out_enq_v    = w_word;
   assign bus.out_enq_last = w_nonempty & (r_k == w_last_k);
   assign bus.busy         = w_nonempty;

   assign w_push = bus.in_enq__ENA & bus.in_enq__RDY;
   assign w_xfer = bus.out_enq__ENA;
   assign w_pop  = w_xfer & bus.out_enq_last;

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_k     <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         if (w_xfer) r_k <= w_pop ? 2'd0 : r_k + 2'd1;
      end
   end

   // Payload storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wptr] <= bus.in_enq_v;
   end

   a_no_push_when_full: assert property (
      @(posedge CLK) disable iff (nRST) !(bus.in_enq__ENA && !bus.in_enq__RDY)
   );
endmodule
